// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access controller: RV32I load/store
// funct3 encodings, the controller state type, and the lane helper functions.
package dmem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD0,
        ST_RD1,
        ST_WR1,
        ST_RESP
    } state_t;

    // Byte-lane mask of an access of the given size code, before shifting by offset.
    function automatic logic [3:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            2'b10:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Size in bytes for the size code (0 for the reserved code).
    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            2'b10:   return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    // An access crosses a word boundary when its last byte lies beyond lane 3.
    function automatic logic is_split(input logic [1:0] off, input logic [1:0] sz);
        return ({1'b0, off} + size_bytes(sz)) > 3'd4;
    endfunction

    function automatic logic legal_funct3(input logic we, input logic [2:0] f3);
        if (we) begin
            return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        end
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_lane_align.sv
// Combinational byte-lane steering: store enables/data for both beats of an
// access, and load-data shift plus sign/zero extension from a word pair.
module dmem_access_ctrl_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] word0_i,
    input  logic [31:0] word1_i,
    output logic [3:0]  we0_o,
    output logic [31:0] wdata0_o,
    output logic [3:0]  we1_o,
    output logic [31:0] wdata1_o,
    output logic [31:0] load_o
);

    logic [7:0]  mask8;
    logic [63:0] data64;
    logic [31:0] shifted;

    // The upper halves of the shifted mask/data are exactly the second-beat lanes.
    assign mask8    = {4'b0000, size_mask(funct3_i[1:0])} << off_i;
    assign data64   = {32'b0, wdata_i} << {off_i, 3'b000};
    assign we0_o    = mask8[3:0];
    assign we1_o    = mask8[7:4];
    assign wdata0_o = data64[31:0];
    assign wdata1_o = data64[63:32];

    assign shifted  = 32'({word1_i, word0_i} >> {off_i, 3'b000});

    // Extend the low byte/half of the shifted pair according to the load type.
    always_comb begin
        // NOTE: assigning a default first keeps this block free of inferred latches.
        load_o = shifted;
        case (funct3_i)
            F3_LB:   load_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   load_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  load_o = {24'b0, shifted[7:0]};
            F3_LHU:  load_o = {16'b0, shifted[15:0]};
            default: load_o = shifted;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Load/store sequencer between the MEM stage and BRAM port B (1-cycle read
// latency, byte write enables). Word-crossing accesses are split into two
// beats when DMEM_MISALIGN_EN is defined; otherwise they fault.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_fault,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_t              state_q, state_d;
    logic [1:0]          off_q, off_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [ADDR_W-1:0]   widx_q, widx_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                split_q, split_d;
    logic [31:0]         word0_q, word0_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                fault_q, fault_d;

    logic [1:0]          req_off;
    logic [ADDR_W-1:0]   req_widx;
    logic                req_split;
    logic                req_fault;
    logic [ADDR_W-1:0]   widx_inc;
    logic                unused_addr_hi;

    logic [1:0]          la_off;
    logic [2:0]          la_funct3;
    logic [31:0]         la_wdata;
    logic [31:0]         la_word0;
    logic [31:0]         la_word1;
    logic [3:0]          la_we0, la_we1;
    logic [31:0]         la_wdata0, la_wdata1;
    logic [31:0]         la_load;

    assign req_off        = req_addr[1:0];
    assign req_widx       = req_addr[ADDR_W+1:2];
    assign req_split      = is_split(req_off, req_funct3[1:0]);
    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];
    assign widx_inc       = widx_q + ADDR_W'(1);

`ifdef DMEM_MISALIGN_EN
    assign req_fault = !legal_funct3(req_we, req_funct3);
`else
    assign req_fault = !legal_funct3(req_we, req_funct3) || req_split;
`endif

    // Beat 0 is steered from the live request; later beats from the latched copy.
    assign la_off    = (state_q == ST_IDLE) ? req_off    : off_q;
    assign la_funct3 = (state_q == ST_IDLE) ? req_funct3 : funct3_q;
    assign la_wdata  = (state_q == ST_IDLE) ? req_wdata  : wdata_q;
    assign la_word0  = (state_q == ST_RD1)  ? word0_q    : mem_rdata;
    assign la_word1  = (state_q == ST_RD1)  ? mem_rdata  : 32'b0;

    dmem_access_ctrl_lane_align u_lane_align (
        .off_i    (la_off),
        .funct3_i (la_funct3),
        .wdata_i  (la_wdata),
        .word0_i  (la_word0),
        .word1_i  (la_word1),
        .we0_o    (la_we0),
        .wdata0_o (la_wdata0),
        .we1_o    (la_we1),
        .wdata1_o (la_wdata1),
        .load_o   (la_load)
    );

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = rdata_q;
    assign resp_fault = fault_q;

    // Next-state, request latching and BRAM port drive for each beat.
    always_comb begin
        state_d   = state_q;
        off_d     = off_q;
        funct3_d  = funct3_q;
        widx_d    = widx_q;
        wdata_d   = wdata_q;
        split_d   = split_q;
        word0_d   = word0_q;
        rdata_d   = rdata_q;
        fault_d   = fault_q;
        mem_en    = 1'b0;
        mem_addr  = '0;
        mem_we    = 4'b0000;
        mem_wdata = 32'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    off_d    = req_off;
                    funct3_d = req_funct3;
                    widx_d   = req_widx;
                    wdata_d  = req_wdata;
                    split_d  = req_split;
                    rdata_d  = 32'b0;
                    fault_d  = req_fault;
                    if (req_fault) begin
                        state_d = ST_RESP;
                    end else if (req_we) begin
                        mem_en    = 1'b1;
                        mem_addr  = req_widx;
                        mem_we    = la_we0;
                        mem_wdata = la_wdata0;
`ifdef DMEM_MISALIGN_EN
                        state_d   = req_split ? ST_WR1 : ST_RESP;
`else
                        state_d   = ST_RESP;
`endif
                    end else begin
                        mem_en   = 1'b1;
                        mem_addr = req_widx;
                        state_d  = ST_RD0;
                    end
                end
            end
            ST_RD0: begin
`ifdef DMEM_MISALIGN_EN
                if (split_q) begin
                    word0_d  = mem_rdata;
                    mem_en   = 1'b1;
                    mem_addr = widx_inc;
                    state_d  = ST_RD1;
                end else begin
                    rdata_d = la_load;
                    state_d = ST_RESP;
                end
`else
                rdata_d = la_load;
                state_d = ST_RESP;
`endif
            end
`ifdef DMEM_MISALIGN_EN
            ST_RD1: begin
                rdata_d = la_load;
                state_d = ST_RESP;
            end
            ST_WR1: begin
                mem_en    = 1'b1;
                mem_addr  = widx_inc;
                mem_we    = la_we1;
                mem_wdata = la_wdata1;
                state_d   = ST_RESP;
            end
`endif
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latched-request registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q  <= ST_IDLE;
            off_q    <= 2'b00;
            funct3_q <= 3'b000;
            widx_q   <= '0;
            wdata_q  <= 32'b0;
            split_q  <= 1'b0;
            word0_q  <= 32'b0;
            rdata_q  <= 32'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            off_q    <= off_d;
            funct3_q <= funct3_d;
            widx_q   <= widx_d;
            wdata_q  <= wdata_d;
            split_q  <= split_d;
            word0_q  <= word0_d;
            rdata_q  <= rdata_d;
            fault_q  <= fault_d;
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed self-checking bench for dmem_access_ctrl with a behavioural BRAM.
// Misaligned-access checks follow DMEM_MISALIGN_EN.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_mem = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'b0;
    logic [31:0] req_wdata = 32'b0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        mem_en;
    logic [11:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [4096];
    logic [11:0] b_addr [16];
    logic [3:0]  b_we [16];
    logic [31:0] b_wd [16];
    int          beat_cnt = 0;

    dmem_access_ctrl #(.ADDR_W(12)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault),
        .mem_en     (mem_en),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural BRAM: synchronous read, byte writes, preload while load_mem is high.
    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 32'h0;
            mem[12'h040] <= 32'h44332211;
            mem[12'h041] <= 32'h88776655;
            mem[12'hFFF] <= 32'hDDCCBBAA;
            mem[12'h000] <= 32'h11223344;
            mem_rdata    <= 32'h0;
        end else if (mem_en) begin
            mem_rdata <= mem[mem_addr];
            for (int i = 0; i < 4; i++) begin
                if (mem_we[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
    end

    // Log every BRAM beat for later inspection.
    always @(posedge clk) begin
        if (mem_en) begin
            b_addr[beat_cnt[3:0]] <= mem_addr;
            b_we[beat_cnt[3:0]]   <= mem_we;
            b_wd[beat_cnt[3:0]]   <= mem_wdata;
            beat_cnt              <= beat_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request; return latency in cycles, response data/fault and beat log start.
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, output int lat, output logic [31:0] rd,
                           output logic flt, output int nb, output int b0);
        logic done;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        b0   = beat_cnt;
        lat  = 0;
        done = 1'b0;
        rd   = 32'h0;
        flt  = 1'b0;
        for (int c = 0; c < 10 && !done; c++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            req_valid = 1'b0;
            if (resp_valid) begin
                done = 1'b1;
                rd   = resp_rdata;
                flt  = resp_fault;
            end
        end
        check("resp_seen", 32'(done), 32'd1);
        nb = beat_cnt - b0;
        @(negedge clk);
        check("resp_one_cycle", {30'b0, resp_valid, req_ready}, 32'h1);
    endtask

    int          lat, nb, b0;
    logic [31:0] rd;
    logic        flt;
    logic [3:0]  ix;

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst      = 1'b0;
        load_mem = 1'b0;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_resp", {resp_rdata[30:0], resp_valid}, 32'h0);
        check("rst_fault", 32'(resp_fault), 32'd0);
        check("rst_mem", {18'b0, mem_en, mem_we, mem_addr}, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);

        // Aligned word load
        run_req(1'b0, 3'b010, 32'h100, 32'h0, lat, rd, flt, nb, b0);
        ix = b0[3:0];
        check("lw_lat", 32'(lat), 32'd2);
        check("lw_data", rd, 32'h44332211);
        check("lw_fault", 32'(flt), 32'd0);
        check("lw_beats", 32'(nb), 32'd1);
        check("lw_addr", 32'(b_addr[ix]), 32'h040);
        check("lw_no_we", 32'(b_we[ix]), 32'h0);

        // Sub-word loads
        run_req(1'b0, 3'b000, 32'h107, 32'h0, lat, rd, flt, nb, b0);
        check("lb_lat", 32'(lat), 32'd2);
        check("lb_data", rd, 32'hFFFFFF88);
        run_req(1'b0, 3'b100, 32'h107, 32'h0, lat, rd, flt, nb, b0);
        check("lbu_lat", 32'(lat), 32'd2);
        check("lbu_data", rd, 32'h00000088);
        run_req(1'b0, 3'b101, 32'h102, 32'h0, lat, rd, flt, nb, b0);
        check("lhu_lat", 32'(lat), 32'd2);
        check("lhu_data", rd, 32'h00004433);

        // Illegal funct3
        run_req(1'b0, 3'b011, 32'h100, 32'h0, lat, rd, flt, nb, b0);
        check("badld_lat", 32'(lat), 32'd1);
        check("badld_fault", 32'(flt), 32'd1);
        check("badld_data", rd, 32'h0);
        check("badld_beats", 32'(nb), 32'd0);
        run_req(1'b1, 3'b100, 32'h100, 32'hFFFFFFFF, lat, rd, flt, nb, b0);
        check("badst_fault", 32'(flt), 32'd1);
        check("badst_beats", 32'(nb), 32'd0);
        check("badst_mem", mem[12'h040], 32'h44332211);

        // Aligned sub-word stores then read-back
        run_req(1'b1, 3'b001, 32'h202, 32'h1234BEEF, lat, rd, flt, nb, b0);
        ix = b0[3:0];
        check("sh_lat", 32'(lat), 32'd1);
        check("sh_fault", 32'(flt), 32'd0);
        check("sh_beats", 32'(nb), 32'd1);
        check("sh_we", 32'(b_we[ix]), 32'hC);
        check("sh_wdata", b_wd[ix], 32'hBEEF0000);
        check("sh_mem", mem[12'h080], 32'hBEEF0000);
        run_req(1'b1, 3'b000, 32'h201, 32'h000000A5, lat, rd, flt, nb, b0);
        ix = b0[3:0];
        check("sb_we", 32'(b_we[ix]), 32'h2);
        check("sb_mem", mem[12'h080], 32'hBEEFA500);
        run_req(1'b0, 3'b010, 32'h200, 32'h0, lat, rd, flt, nb, b0);
        check("lw200_data", rd, 32'hBEEFA500);
        run_req(1'b0, 3'b001, 32'h202, 32'h0, lat, rd, flt, nb, b0);
        check("lh202_data", rd, 32'hFFFFBEEF);

`ifdef DMEM_MISALIGN_EN
        // Split load
        run_req(1'b0, 3'b010, 32'h103, 32'h0, lat, rd, flt, nb, b0);
        ix = b0[3:0];
        check("slw_lat", 32'(lat), 32'd3);
        check("slw_data", rd, 32'h77665544);
        check("slw_beats", 32'(nb), 32'd2);
        check("slw_addr0", 32'(b_addr[ix]), 32'h040);
        check("slw_addr1", 32'(b_addr[ix + 4'd1]), 32'h041);

        // Split store
        run_req(1'b1, 3'b010, 32'h102, 32'hAABBCCDD, lat, rd, flt, nb, b0);
        ix = b0[3:0];
        check("ssw_lat", 32'(lat), 32'd2);
        check("ssw_beats", 32'(nb), 32'd2);
        check("ssw_addr0", 32'(b_addr[ix]), 32'h040);
        check("ssw_we0", 32'(b_we[ix]), 32'hC);
        check("ssw_wd0", b_wd[ix], 32'hCCDD0000);
        check("ssw_addr1", 32'(b_addr[ix + 4'd1]), 32'h041);
        check("ssw_we1", 32'(b_we[ix + 4'd1]), 32'h3);
        check("ssw_wd1", b_wd[ix + 4'd1], 32'h0000AABB);
        check("ssw_mem0", mem[12'h040], 32'hCCDD2211);
        check("ssw_mem1", mem[12'h041], 32'h8877AABB);

        // Split load across the top of memory
        run_req(1'b0, 3'b010, 32'h3FFD, 32'h0, lat, rd, flt, nb, b0);
        ix = b0[3:0];
        check("wrap_addr0", 32'(b_addr[ix]), 32'hFFF);
        check("wrap_addr1", 32'(b_addr[ix + 4'd1]), 32'h000);
        check("wrap_data", rd, 32'h44DDCCBB);

        // Reset while waiting for the second read beat
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h103;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rd1_busy", 32'(req_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_ready", 32'(req_ready), 32'd1);
        check("rstmid_resp", 32'(resp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("rstmid_resp2", 32'(resp_valid), 32'd0);

        run_req(1'b0, 3'b010, 32'h104, 32'h0, lat, rd, flt, nb, b0);
        check("post_rst_lw", rd, 32'h8877AABB);
`else
        // Word-crossing accesses fault when splitting is disabled
        run_req(1'b0, 3'b001, 32'h103, 32'h0, lat, rd, flt, nb, b0);
        check("mislh_lat", 32'(lat), 32'd1);
        check("mislh_fault", 32'(flt), 32'd1);
        check("mislh_data", rd, 32'h0);
        check("mislh_beats", 32'(nb), 32'd0);
        run_req(1'b1, 3'b010, 32'h102, 32'hAABBCCDD, lat, rd, flt, nb, b0);
        check("missw_fault", 32'(flt), 32'd1);
        check("missw_beats", 32'(nb), 32'd0);
        check("missw_mem0", mem[12'h040], 32'h44332211);
        check("missw_mem1", mem[12'h041], 32'h88776655);
        run_req(1'b0, 3'b010, 32'h3FFD, 32'h0, lat, rd, flt, nb, b0);
        check("miswrap_fault", 32'(flt), 32'd1);

        // Reset while waiting for read data
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("rd0_busy", 32'(req_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_ready", 32'(req_ready), 32'd1);
        check("rstmid_resp", 32'(resp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("rstmid_resp2", 32'(resp_valid), 32'd0);

        run_req(1'b0, 3'b010, 32'h104, 32'h0, lat, rd, flt, nb, b0);
        check("post_rst_lw", rd, 32'h88776655);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
